// File: rtl/display_timings.sv
// ============================================================================
// display_timings
// ----------------------------------------------------------------------------
// Raster timing generator for VGA/HDMI-style video. Two counters (sx across a
// line, sy down a frame) advance on every pixel clock edge where en=1. All
// sync / blanking strobes are pure decodes of the coordinate registers, so
// they line up exactly with sx/sy with no pipeline offset.
//
// Optional feature:
//   DISPLAY_TIMINGS_FRAME_CNT_EN  - when defined, adds a 16-bit frame_cnt
//                                   output counting completed frames.
//
// Ports:
//   clk_pix    in   pixel clock (only clock)
//   rst_pix_n  in   synchronous active-low reset, returns raster to (0,0)
//   en         in   pixel advance enable (for divided pixel rates)
//   sx         out  [CORDW-1:0] horizontal position (registered)
//   sy         out  [CORDW-1:0] vertical position (registered)
//   hsync      out  horizontal sync, H_POL level while active
//   vsync      out  vertical sync, V_POL level while active
//   de         out  data enable, high only in the visible area
//   line       out  high while sx==0
//   frame      out  high while sx==0 and sy==0
//   frame_cnt  out  [15:0] completed frame count (macro builds only)
// ============================================================================
module display_timings #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame
`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived totals and decode boundaries
    // ------------------------------------------------------------------------
    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;

    // Last coordinate of a line / frame; these always fit in CORDW bits
    // because the totals are bounded by 2**CORDW below.
    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOT - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOT - 1);

    // Region boundaries are held at 32 bits: the end of the sync window can
    // equal the total, which may be exactly 2**CORDW and not fit in CORDW.
    localparam logic [31:0] H_ACT_END = 32'(H_RES);
    localparam logic [31:0] HS_BEG    = 32'(H_RES + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_RES + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_RES);
    localparam logic [31:0] VS_BEG    = 32'(V_RES + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_RES + V_FP + V_SYNC);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (CORDW < 1 || CORDW > 30) begin : g_chk_cordw
        $error("display_timings: CORDW must be in 1..30");
    end
    if (H_TOT > (1 << CORDW)) begin : g_chk_h_tot
        $error("display_timings: H_TOT does not fit in CORDW bits");
    end
    if (V_TOT > (1 << CORDW)) begin : g_chk_v_tot
        $error("display_timings: V_TOT does not fit in CORDW bits");
    end
    if (H_RES < 1 || V_RES < 1) begin : g_chk_res
        $error("display_timings: active resolution must be non-zero");
    end
    if (H_FP < 0 || H_SYNC < 0 || H_BP < 0 ||
        V_FP < 0 || V_SYNC < 0 || V_BP < 0) begin : g_chk_porch
        $error("display_timings: porch and sync widths must be non-negative");
    end

    // ------------------------------------------------------------------------
    // Coordinate counters
    // ------------------------------------------------------------------------
    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (en) begin
            if (sx_q == H_LAST) begin
                // End of line: wrap horizontally and step to the next line,
                // wrapping the frame after the last line.
                sx_d = '0;
                if (sy_q == V_LAST) begin
                    sy_d = '0;
                end else begin
                    sy_d = sy_q + 1'b1;
                end
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end
    end

    // Reset wins over any count, wrap included.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Zero-latency decodes of the coordinate registers
    // ------------------------------------------------------------------------
    logic [31:0] sx_w;
    logic [31:0] sy_w;
    logic        hs_act;
    logic        vs_act;

    assign sx_w = 32'(sx_q);
    assign sy_w = 32'(sy_q);

    // vsync depends only on sy, so its edges naturally fall on the cycle
    // where sx has just wrapped to 0.
    assign hs_act = (sx_w >= HS_BEG) && (sx_w < HS_END);
    assign vs_act = (sy_w >= VS_BEG) && (sy_w < VS_END);

    assign sx    = sx_q;
    assign sy    = sy_q;
    assign hsync = hs_act ? HS_ON : ~HS_ON;
    assign vsync = vs_act ? VS_ON : ~VS_ON;
    assign de    = (sx_w < H_ACT_END) && (sy_w < V_ACT_END);
    assign line  = (sx_q == '0);
    assign frame = (sx_q == '0) && (sy_q == '0);

`ifdef DISPLAY_TIMINGS_FRAME_CNT_EN
    // ------------------------------------------------------------------------
    // Completed-frame counter; rolls over naturally at 16 bits.
    // ------------------------------------------------------------------------
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_wrap;

    assign frame_wrap = en && (sx_q == H_LAST) && (sy_q == V_LAST);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
